ram_mm2s_reader: RTL and testbench
==================================

Name: ram_mm2s_reader

Overview:
Read-side DMA engine that sits directly downstream of a top_ram mm2s read port (mm2s_N_ren / mm2s_N_addr / mm2s_N_data) and consumes the word-addressed RAM data it produces.
- Accepts one read command at a time: byte base address plus byte count.
- Issues word reads against the 1-cycle-latency RAM port.
- Buffers the returned words in a small credit-controlled FIFO.
- Emits them as an AXI-Stream with tkeep/tlast.
One instance sits per mm2s port, feeding the systolic-array input streams.

Parameters:
AXI_WIDTH, 128, RAM/stream data width in bits.
AXI_ADDR_WIDTH, 32, byte-address width.
LSB, $clog2(AXI_WIDTH)-3, byte-offset bits dropped to form the word address.
LEN_WIDTH, 32, width of the byte-count field.
FIFO_DEPTH, 4, output buffer depth in words (power of 2, ≥2).

Ports:
clk  in  1  clock; all logic on its rising edge.
rst  in  1  reset, asynchronous, active-high.
cmd_valid  in  1  command valid.
cmd_ready  out  1  command ready; high only in IDLE.
cmd_addr  in  AXI_ADDR_WIDTH  byte base address; low LSB bits ignored.
cmd_bytes  in  LEN_WIDTH  transfer length in bytes.
mem_ren  out  1  RAM read enable.
mem_addr  out  AXI_ADDR_WIDTH-LSB  RAM word address.
mem_data  in  AXI_WIDTH  RAM read data; valid on the cycle after the edge that sampled mem_ren=1; holds its value otherwise.
m_axis_tdata  out  AXI_WIDTH  stream data.
m_axis_tkeep  out  AXI_WIDTH/8  byte enables.
m_axis_tlast  out  1  last beat of the command.
m_axis_tvalid  out  1  stream valid.
m_axis_tready  in  1  stream ready.
busy  out  1  high in RUN/ZERO.
done  out  1  one-cycle pulse at command completion.

Behaviour:
- Reset values:
  - Outputs: cmd_ready=1, mem_ren=0, mem_addr=0, m_axis_tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, done=0.
  - Internals: FIFO empty, in-flight flag clear.
- States:
  - IDLE: cmd_ready=1.
    - cmd_valid&&cmd_ready with cmd_bytes==0 → ZERO.
    - cmd_valid&&cmd_ready with cmd_bytes>0 → RUN. On entry, latch: word pointer = cmd_addr[AXI_ADDR_WIDTH-1:LSB]; issue_cnt = beats = ceil(cmd_bytes/(AXI_WIDTH/8)); out_cnt = beats; tail = cmd_bytes mod (AXI_WIDTH/8).
  - ZERO: done=1 for exactly one cycle, no beats, no mem_ren → IDLE.
  - RUN:
    - mem_ren=1 when issue_cnt>0 AND (fifo_count + inflight) < FIFO_DEPTH; mem_addr = pointer.
    - On each issue: pointer+1, wrapping modulo 2^(AXI_ADDR_WIDTH-LSB); issue_cnt-1.
    - inflight = registered mem_ren. When inflight=1, mem_data is pushed into the FIFO on that edge.
    - Credit rule: the FIFO never overflows, even with tready held low.
- Stream output:
  - FIFO head drives tdata/tvalid. Pop on tvalid&&tready; out_cnt-1 per pop.
  - tlast=1 when out_cnt==1.
  - tkeep all ones, except on the tlast beat when tail≠0: tkeep = (1<<tail)-1.
  - tdata, tkeep and tlast stay stable while tvalid&&!tready.
- Completion: the tlast handshake → done pulse on the next cycle, state → IDLE. cmd_ready=1 in that same cycle.
- Latency: cmd handshake at edge 0 → mem_ren high in cycle 1 → mem_data valid in cycle 2 → tvalid high in cycle 3.
- Throughput: 1 beat/cycle sustained with tready=1 and FIFO_DEPTH≥3.
- Simultaneous push and pop on the same edge: count unchanged; legal when full or empty.
- Reset mid-transfer: returns immediately to the reset values and the FIFO is flushed. The RAM response from a read issued before reset is discarded.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
RD_STATS_EN.
- Defined: adds outputs stat_beats [31:0] (total beats handshaked) and stat_stalls [31:0] (cycles with tvalid&&!tready).
  - Both cleared on rst and on each command acceptance; both saturate at 2^32-1.
- Undefined: neither the ports nor the counters exist; behaviour otherwise identical.

Test Plan:
- Aligned read: cmd_addr=0x100, cmd_bytes=64, tready=1 → mem_addr 0x10..0x13 on consecutive cycles; 4 beats with tkeep=0xFFFF; tlast on beat 4; first tvalid 3 cycles after cmd; done pulse 1 cycle after the last beat.
- Partial tail: cmd_bytes=20 → 2 beats; beat 2 tkeep=0x000F with tlast=1.
- Backpressure: cmd_bytes=160, tready low for 20 cycles then high → reads stop once fifo_count+inflight=4; no data loss; data order matches RAM.
- Zero length: cmd_bytes=0 → no mem_ren, no tvalid; done=1 the cycle after accept; cmd_ready back to 1.
- Wrap: cmd_addr=0xFFFFFFF0, cmd_bytes=32 → mem_addr 0x0FFFFFFF then 0x0000000; 2 beats.
- Reset mid-run: rst asserted after beat 2 of 8 → tvalid, mem_ren and busy low immediately; the next command streams correct data from its own base.

Source files
------------

// File: rtl/ram_mm2s_reader.sv
// Read-side DMA: turns a byte-addressed read command into word reads on a 1-cycle RAM port
// and streams the words out as AXI-Stream. Define RD_STATS_EN to add beat/stall counters.
module ram_mm2s_reader #(
  parameter int AXI_WIDTH      = 128,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LSB            = $clog2(AXI_WIDTH) - 3,
  parameter int LEN_WIDTH      = 32,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [LEN_WIDTH-1:0]          cmd_bytes,
  output logic                          mem_ren,
  output logic [AXI_ADDR_WIDTH-LSB-1:0] mem_addr,
  input  logic [AXI_WIDTH-1:0]          mem_data,
  output logic [AXI_WIDTH-1:0]          m_axis_tdata,
  output logic [AXI_WIDTH/8-1:0]        m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic                          done
`ifdef RD_STATS_EN
  ,
  output logic [31:0]                   stat_beats,
  output logic [31:0]                   stat_stalls
`endif
);

  localparam int BYTES = AXI_WIDTH / 8;
  localparam int WAW   = AXI_ADDR_WIDTH - LSB;
  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WAW-1:0]       PTR_ONE  = {{(WAW-1){1'b0}}, 1'b1};
  localparam logic [FAW-1:0]       FPTR_ONE = {{(FAW-1){1'b0}}, 1'b1};
  localparam logic [FAW:0]         CNT_ONE  = {{FAW{1'b0}}, 1'b1};
  localparam logic [FAW+1:0]       DEPTH_L  = (FAW+2)'(FIFO_DEPTH);
  localparam logic [BYTES-1:0]     KEEP_ONE = {{(BYTES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WAW-1:0]        r_ptr;
  logic [LEN_WIDTH-1:0]  r_issue_cnt;
  logic [LEN_WIDTH-1:0]  r_out_cnt;
  logic [LSB-1:0]        r_tail;
  logic                  r_inflight;
  logic                  r_done;
  logic [AXI_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [FAW-1:0]        r_wptr;
  logic [FAW-1:0]        r_rptr;
  logic [FAW:0]          r_count;

  logic                  w_accept;
  logic                  w_zero_cmd;
  logic [LEN_WIDTH-1:0]  w_beats;
  logic [FAW+1:0]        w_used;
  logic                  w_ren;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_pop;
  logic                  w_valid;
  logic [BYTES-1:0]      w_tail_mask;
  logic                  w_unused;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_zero_cmd  = (cmd_bytes == LEN_ZERO);
  assign w_beats     = (cmd_bytes >> LSB) + {{(LEN_WIDTH-1){1'b0}}, |cmd_bytes[LSB-1:0]};
  // Reads in flight are counted against the buffer so a stalled sink can never overflow it.
  assign w_used      = {1'b0, r_count} + {{(FAW+1){1'b0}}, r_inflight};
  assign w_ren       = (r_state == S_RUN) && (r_issue_cnt != LEN_ZERO) && (w_used < DEPTH_L);
  assign w_push      = r_inflight;
  assign w_valid     = (r_count != {(FAW+1){1'b0}});
  assign w_pop       = w_valid && m_axis_tready;
  assign w_last_pop  = w_pop && (r_out_cnt == LEN_ONE);
  assign w_tail_mask = (KEEP_ONE << r_tail) - KEEP_ONE;
  assign w_unused    = ^cmd_addr[LSB-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_zero_cmd ? S_ZERO : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last_pop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_ZERO:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command latch, read issue and beat accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= {WAW{1'b0}};
      r_issue_cnt <= LEN_ZERO;
      r_out_cnt   <= LEN_ZERO;
      r_tail      <= {LSB{1'b0}};
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_inflight <= w_ren;
      r_done     <= (w_accept && w_zero_cmd) || w_last_pop;
      if (w_accept) begin
        r_ptr       <= cmd_addr[AXI_ADDR_WIDTH-1:LSB];
        r_issue_cnt <= w_beats;
        r_out_cnt   <= w_beats;
        r_tail      <= cmd_bytes[LSB-1:0];
      end else begin
        if (w_ren) begin
          r_ptr       <= r_ptr + PTR_ONE;
          r_issue_cnt <= r_issue_cnt - LEN_ONE;
        end
        if (w_pop) begin
          r_out_cnt <= r_out_cnt - LEN_ONE;
        end
      end
    end
  end

  // Output FIFO; the RAM response is captured on the edge after its read was issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= {AXI_WIDTH{1'b0}};
      end
      r_wptr  <= {FAW{1'b0}};
      r_rptr  <= {FAW{1'b0}};
      r_count <= {(FAW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= mem_data;
        r_wptr        <= r_wptr + FPTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FPTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stream sideband from the FIFO head and beat counter.
  always_comb begin
    m_axis_tlast = w_valid && (r_out_cnt == LEN_ONE);
    if (!w_valid) begin
      m_axis_tkeep = {BYTES{1'b0}};
    end else if (m_axis_tlast && (r_tail != {LSB{1'b0}})) begin
      m_axis_tkeep = w_tail_mask;
    end else begin
      m_axis_tkeep = {BYTES{1'b1}};
    end
  end

  assign m_axis_tdata  = r_mem[r_rptr];
  assign m_axis_tvalid = w_valid;
  assign mem_ren       = w_ren;
  assign mem_addr      = r_ptr;
  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state == S_RUN) || (r_state == S_ZERO);
  assign done          = r_done;

`ifdef RD_STATS_EN
  // Saturating beat and stall counters, cleared per command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats  <= 32'd0;
      stat_stalls <= 32'd0;
    end else if (w_accept) begin
      stat_beats  <= 32'd0;
      stat_stalls <= 32'd0;
    end else begin
      if (w_pop && (stat_beats != 32'hFFFF_FFFF)) begin
        stat_beats <= stat_beats + 32'd1;
      end
      if (w_valid && !m_axis_tready && (stat_stalls != 32'hFFFF_FFFF)) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_mm2s_reader.sv
// Scoreboard bench for ram_mm2s_reader: expected beats are queued per command from the
// command fields and compared on every stream handshake.
module tb_ram_mm2s_reader;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [31:0]  cmd_addr = 32'd0;
  logic [31:0]  cmd_bytes = 32'd0;
  logic         mem_ren;
  logic [27:0]  mem_addr;
  logic [127:0] mem_data = 128'd0;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         busy;
  logic         done;
`ifdef RD_STATS_EN
  logic [31:0]  stat_beats;
  logic [31:0]  stat_stalls;
`endif

  int checks = 0;
  int errors = 0;
  beat_t sb_q[$];
  logic [27:0] addr_log[$];

  ram_mm2s_reader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_data(mem_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .busy(busy), .done(done)
`ifdef RD_STATS_EN
    , .stat_beats(stat_beats), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ram_word(input logic [27:0] a);
    return {4'hA, a, ~{4'h0, a}, {a, 4'h5} ^ 32'h1234_5678, 4'h3, a};
  endfunction

  // RAM model: one-cycle read latency, output holds when not reading.
  always @(posedge clk) begin
    if (mem_ren) mem_data <= ram_word(mem_addr);
  end

  task automatic push_expected(input logic [31:0] addr, input logic [31:0] bytes);
    int beats;
    logic [3:0] tail;
    logic [27:0] w;
    beat_t b;
    tail  = bytes[3:0];
    beats = int'(bytes >> 4) + ((tail != 4'd0) ? 1 : 0);
    w     = addr[31:4];
    for (int i = 0; i < beats; i++) begin
      b.data = ram_word(w);
      b.last = (i == beats - 1);
      b.keep = (b.last && tail != 4'd0) ? ((16'd1 << tail) - 16'd1) : 16'hFFFF;
      sb_q.push_back(b);
      w = w + 28'd1;
    end
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] bytes);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_bytes = bytes;
    addr_log.delete();
    push_expected(addr, bytes);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Runs cycles from cycle 1 after the command edge; returns on done, after stop_beats pops, or on timeout.
  task automatic drain(input int budget, input int stall, input int stop_beats,
                       output int first_valid, output int done_cyc, output int ren_stall);
    int pops;
    beat_t exp_b;
    first_valid = -1; done_cyc = -1; ren_stall = 0; pops = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (stop_beats != 0 && pops >= stop_beats) return;
      if (mem_ren) begin
        addr_log.push_back(mem_addr);
        if (cyc <= stall) ren_stall++;
      end
      if (done) begin
        done_cyc = cyc;
        return;
      end
      m_axis_tready = (cyc > stall);
      if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected cyc=%0d got data=%h", cyc, m_axis_tdata);
        end else begin
          exp_b = sb_q.pop_front();
          if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== exp_b) begin
            errors++;
            $display("FAIL beat cyc=%0d got data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                     cyc, m_axis_tdata, m_axis_tkeep, m_axis_tlast, exp_b.data, exp_b.keep, exp_b.last);
          end
        end
        pops++;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL drain_timeout budget=%0d pops=%0d", budget, pops);
  endtask

  task automatic check_int(input string name, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s beats_left got=%0d exp=0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, mem_ren, mem_addr, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, busy, done}
        !== {1'b1, 1'b0, 28'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b ren=%b addr=%h vld=%b last=%b keep=%h busy=%b done=%b",
               cmd_ready, mem_ren, mem_addr, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, busy, done);
    end
    checks++;
    if (m_axis_tdata !== 128'd0) begin
      errors++;
      $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata);
    end
  endtask

  task automatic test_aligned();
    int fv, dc, rs;
    send_cmd(32'h0000_0100, 32'd64);
    drain(60, 0, 0, fv, dc, rs);
    check_int("aligned_first_valid", fv, 3);
    check_int("aligned_done_cycle", dc, 7);
    check_int("aligned_ready_at_done", int'(cmd_ready), 1);
    check_int("aligned_reads", addr_log.size(), 4);
    for (int i = 0; i < addr_log.size(); i++)
      check_int("aligned_mem_addr", int'(addr_log[i]), 32'h10 + i);
    check_sb_empty("aligned");
    @(negedge clk);
    check_int("aligned_done_one_cycle", int'(done), 0);
  endtask

  task automatic test_partial_tail();
    int fv, dc, rs;
    send_cmd(32'h0000_0200, 32'd20);
    drain(60, 0, 0, fv, dc, rs);
    check_int("partial_done_cycle", dc, 5);
    check_int("partial_reads", addr_log.size(), 2);
    check_sb_empty("partial");
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int fv, dc, rs;
    send_cmd(32'h0000_0300, 32'd160);
    drain(200, 20, 0, fv, dc, rs);
    check_int("bp_reads_while_stalled", rs, 4);
    check_int("bp_total_reads", addr_log.size(), 10);
    check_sb_empty("backpressure");
    @(negedge clk);
  endtask

  task automatic test_zero_length();
    int fv, dc, rs;
    send_cmd(32'h0000_0500, 32'd0);
    drain(20, 0, 0, fv, dc, rs);
    check_int("zero_done_cycle", dc, 1);
    check_int("zero_ready_low_in_zero", int'(cmd_ready), 0);
    check_int("zero_no_reads", addr_log.size(), 0);
    check_int("zero_no_valid", fv, -1);
    @(negedge clk);
    check_int("zero_ready_back", int'(cmd_ready), 1);
    check_int("zero_done_cleared", int'(done), 0);
  endtask

  task automatic test_wrap();
    int fv, dc, rs;
    send_cmd(32'hFFFF_FFF0, 32'd32);
    drain(60, 0, 0, fv, dc, rs);
    check_int("wrap_reads", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      check_int("wrap_addr0", int'(addr_log[0]), 32'h0FFF_FFFF);
      check_int("wrap_addr1", int'(addr_log[1]), 0);
    end
    check_sb_empty("wrap");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int fv, dc, rs;
    send_cmd(32'h0000_0400, 32'd128);
    drain(60, 0, 2, fv, dc, rs);
    rst = 1'b1;
    #1;
    checks++;
    if ({m_axis_tvalid, mem_ren, busy, cmd_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_outputs got vld=%b ren=%b busy=%b rdy=%b exp 0 0 0 1",
               m_axis_tvalid, mem_ren, busy, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    send_cmd(32'h0000_0800, 32'd48);
    drain(60, 0, 0, fv, dc, rs);
    check_int("midreset_next_first_valid", fv, 3);
    check_int("midreset_next_done_cycle", dc, 6);
    check_sb_empty("midreset_next");
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_partial_tail();
    test_backpressure();
    test_zero_length();
    test_wrap();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
